conv_layer_engine: RTL

CONV_LAYER_ENGINE -- requirements
Module: conv_layer_engine

---
 rtl/conv_layer_engine.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/conv_layer_engine.sv
// conv_layer_engine: streaming 2-D convolution, one KxK kernel over an NxN frame, raster in/out.
// Latency: a feature is valid 2 clk edges after the pixel that completes its window is accepted.
// Backpressure: feat_ready low while a feature is held stalls the whole pipeline and drops pix_ready.
//
// Ports:
//   clk, rst            single rising-edge clock, asynchronous active-high reset
//   start, relu_en      frame kick-off (IDLE only); ReLU mode captured with start
//   w_valid, w_data     KxK weights in raster order, accepted only while loading
//   pix_valid/ready/data  NxN pixels in raster order
//   feat_valid/ready/data/last  output features, raster order, last marks end of frame
//   busy, done          busy outside IDLE; done pulses after the final feature handshake
module conv_layer_engine #(
  parameter int DATA_WIDTH  = 16,
  parameter int IMAGE_SIZE  = 8,
  parameter int KERNEL_SIZE = 3,
  parameter int STRIDE      = 1,
  parameter int ACC_WIDTH   = 2*DATA_WIDTH + $clog2(KERNEL_SIZE*KERNEL_SIZE)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         relu_en,
  input  logic                         w_valid,
  input  logic signed [DATA_WIDTH-1:0] w_data,
  input  logic                         pix_valid,
  output logic                         pix_ready,
  input  logic signed [DATA_WIDTH-1:0] pix_data,
  output logic                         feat_valid,
  input  logic                         feat_ready,
  output logic signed [ACC_WIDTH-1:0]  feat_data,
  output logic                         feat_last,
  output logic                         busy,
  output logic                         done
);

  localparam int NTAP     = KERNEL_SIZE*KERNEL_SIZE;
  localparam int CW       = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1;
  localparam int WCW      = (NTAP > 1) ? $clog2(NTAP) : 1;
  // At least one line buffer is declared so K=1 still elaborates; it is never used then.
  localparam int LB_N     = (KERNEL_SIZE > 1) ? KERNEL_SIZE-1 : 1;
  localparam int PW       = 2*DATA_WIDTH;
  // Row/column of the bottom-right pixel of the last window; with a stride that does not
  // divide (N-K) evenly this is not the final pixel of the frame.
  localparam int LAST_WIN = KERNEL_SIZE-1 + ((IMAGE_SIZE-KERNEL_SIZE)/STRIDE)*STRIDE;

  localparam logic [CW-1:0]  EDGE_MAX = CW'(IMAGE_SIZE-1);
  localparam logic [WCW-1:0] TAP_MAX  = WCW'(NTAP-1);
  localparam logic [31:0]    K_OFS    = 32'(KERNEL_SIZE-1);
  localparam logic [31:0]    STEP     = 32'(STRIDE);
  localparam logic [31:0]    WIN_END  = 32'(LAST_WIN);

  typedef enum logic [1:0] {IDLE, LOAD_W, RUN, DRAIN} state_t;

  state_t state, state_nxt;

  logic signed [DATA_WIDTH-1:0] weights  [NTAP];
  logic signed [DATA_WIDTH-1:0] line_buf [LB_N][IMAGE_SIZE];
  logic signed [DATA_WIDTH-1:0] win      [KERNEL_SIZE][KERNEL_SIZE];

  logic [WCW-1:0] w_cnt;
  logic [CW-1:0]  row, col;
  logic           relu_q;
  logic           s1_vld, s1_last;
  logic           feat_vld_q, feat_last_q;
  logic signed [ACC_WIDTH-1:0] feat_q;
  logic           last_seen;
  logic           done_q;

  logic           adv, pix_acc, w_acc, last_hs, go_idle;
  logic [31:0]    row_i, col_i;
  logic           win_ok, win_last;
  logic signed [ACC_WIDTH-1:0] mac_sum;

  // The output register may advance when it is empty or being drained this cycle.
  assign adv     = !feat_vld_q || feat_ready;
  assign pix_acc = pix_valid && pix_ready;
  assign w_acc   = (state == LOAD_W) && w_valid;
  assign last_hs = feat_vld_q && feat_ready && feat_last_q;
  // The final feature may already have left during RUN (large stride), hence last_seen.
  assign go_idle = (state == DRAIN) && (last_seen || last_hs);

  // Window test for the pixel being accepted: it completes a window when both coordinates
  // have K-1 pixels behind them in this row/frame and sit on the stride grid.
  assign row_i    = 32'(row);
  assign col_i    = 32'(col);
  assign win_ok   = (row_i >= K_OFS) && (col_i >= K_OFS) &&
                    (((row_i - K_OFS) % STEP) == 32'd0) &&
                    (((col_i - K_OFS) % STEP) == 32'd0);
  assign win_last = (row_i == WIN_END) && (col_i == WIN_END);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pix_ready = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = LOAD_W;
      end
      LOAD_W: begin
        if (w_valid && (w_cnt == TAP_MAX)) state_nxt = RUN;
      end
      RUN: begin
        pix_ready = adv;
        if (pix_valid && adv && (row == EDGE_MAX) && (col == EDGE_MAX)) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (last_seen || last_hs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- MAC
  // Full-precision sum: each product and the running sum are sign-extended to ACC_WIDTH,
  // so no intermediate can overflow.
  always_comb begin
    mac_sum = '0;
    for (int r = 0; r < KERNEL_SIZE; r++) begin
      for (int c = 0; c < KERNEL_SIZE; c++) begin
        mac_sum = mac_sum + ACC_WIDTH'(PW'(win[r][c]) * PW'(weights[r*KERNEL_SIZE+c]));
      end
    end
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_cnt       <= '0;
      row         <= '0;
      col         <= '0;
      relu_q      <= 1'b0;
      s1_vld      <= 1'b0;
      s1_last     <= 1'b0;
      feat_vld_q  <= 1'b0;
      feat_last_q <= 1'b0;
      feat_q      <= '0;
      last_seen   <= 1'b0;
      done_q      <= 1'b0;
      for (int i = 0; i < NTAP; i++) weights[i] <= '0;
      for (int j = 0; j < LB_N; j++) begin
        for (int x = 0; x < IMAGE_SIZE; x++) line_buf[j][x] <= '0;
      end
      for (int r = 0; r < KERNEL_SIZE; r++) begin
        for (int c = 0; c < KERNEL_SIZE; c++) win[r][c] <= '0;
      end
    end else begin
      done_q <= go_idle;

      if ((state == IDLE) && start) begin
        w_cnt     <= '0;
        row       <= '0;
        col       <= '0;
        relu_q    <= relu_en;
        last_seen <= 1'b0;
      end

      if (w_acc) begin
        weights[w_cnt] <= w_data;
        w_cnt          <= (w_cnt == TAP_MAX) ? '0 : w_cnt + WCW'(1);
      end

      if (last_hs) last_seen <= 1'b1;

      if (pix_acc) begin
        col <= (col == EDGE_MAX) ? '0 : col + CW'(1);
        if (col == EDGE_MAX) row <= (row == EDGE_MAX) ? '0 : row + CW'(1);

        // line_buf[0] holds the previous row, line_buf[j] the row j+1 above the current one.
        if (KERNEL_SIZE > 1) begin
          line_buf[0][col] <= pix_data;
          for (int j = 1; j < KERNEL_SIZE-1; j++) line_buf[j][col] <= line_buf[j-1][col];
        end

        // Window shifts left; the new right-hand column is the stack of this column's pixels,
        // oldest row at the top (row 0) so it lines up with weight raster order.
        for (int r = 0; r < KERNEL_SIZE; r++) begin
          for (int c = 0; c < KERNEL_SIZE-1; c++) win[r][c] <= win[r][c+1];
        end
        for (int r = 0; r < KERNEL_SIZE-1; r++) begin
          win[r][KERNEL_SIZE-1] <= line_buf[KERNEL_SIZE-2-r][col];
        end
        win[KERNEL_SIZE-1][KERNEL_SIZE-1] <= pix_data;
      end

      // Stage 1 is the window register itself (flagged by s1_vld); stage 2 is the output
      // register. Both freeze together while the output is held.
      if (adv) begin
        s1_vld      <= pix_acc && win_ok;
        s1_last     <= pix_acc && win_ok && win_last;
        feat_vld_q  <= s1_vld;
        feat_last_q <= s1_vld && s1_last;
        if (s1_vld) feat_q <= (relu_q && mac_sum[ACC_WIDTH-1]) ? '0 : mac_sum;
      end
    end
  end

  assign feat_valid = feat_vld_q;
  assign feat_data  = feat_q;
  assign feat_last  = feat_last_q;
  assign done       = done_q;

endmodule
